// File: rtl/bldc_pkg.sv
// Shared types and lookup helpers for the hall-sensor BLDC commutator.
package bldc_pkg;

  typedef enum logic [1:0] {ReqFloat, ReqHigh, ReqLow} phase_req_e;

  typedef enum logic [1:0] {StIdle, StDead, StDrvH, StDrvL} phase_state_e;

  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  typedef struct packed {
    logic [1:0] hi;
    logic [1:0] lo;
  } step_phases_t;

  function automatic logic [2:0] hall_decode(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return SECTOR_INVALID;
    endcase
  endfunction

  function automatic logic [2:0] step_of(input logic [2:0] sector, input logic dir);
    if (!dir) return sector;
    return (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
  endfunction

  // Phase index 3 matches no phase, so an out-of-range step floats everything.
  function automatic step_phases_t step_phases(input logic [2:0] step);
    case (step)
      3'd0:    return '{hi: 2'd0, lo: 2'd1};
      3'd1:    return '{hi: 2'd0, lo: 2'd2};
      3'd2:    return '{hi: 2'd1, lo: 2'd2};
      3'd3:    return '{hi: 2'd1, lo: 2'd0};
      3'd4:    return '{hi: 2'd2, lo: 2'd0};
      3'd5:    return '{hi: 2'd2, lo: 2'd1};
      default: return '{hi: 2'd3, lo: 2'd3};
    endcase
  endfunction

endpackage

// File: rtl/bldc_phase_driver.sv
// One half-bridge: dead-time FSM that turns a phase request into registered gate drives.
module bldc_phase_driver
  import bldc_pkg::*;
#(
  parameter int unsigned DEADTIME_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic       gate_h,
  output logic       gate_l
);

  localparam logic [7:0] DT_LOAD = 8'(DEADTIME_CYCLES - 1);

  phase_req_e   w_req;
  phase_state_e r_state;
  phase_req_e   r_tgt;
  logic [7:0]   r_cnt;
  logic         r_gate_h;
  logic         r_gate_l;

  assign w_req = phase_req_e'(req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_tgt    <= ReqFloat;
      r_cnt    <= 8'd0;
      r_gate_h <= 1'b0;
      r_gate_l <= 1'b0;
    end else if (w_req == ReqFloat) begin
      r_state  <= StIdle;
      r_tgt    <= ReqFloat;
      r_cnt    <= 8'd0;
      r_gate_h <= 1'b0;
      r_gate_l <= 1'b0;
    end else begin
      unique case (r_state)
        StDead: begin
          if (w_req != r_tgt) begin
            r_tgt <= w_req;
            r_cnt <= DT_LOAD;
          end else if (r_cnt == 8'd0) begin
            r_state  <= (r_tgt == ReqHigh) ? StDrvH : StDrvL;
            r_gate_h <= (r_tgt == ReqHigh);
            r_gate_l <= (r_tgt == ReqLow);
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StDrvH, StDrvL: begin
          // Reversing the drive always passes through a full dead-time window.
          if ((r_state == StDrvH) != (w_req == ReqHigh)) begin
            r_state  <= StDead;
            r_tgt    <= w_req;
            r_cnt    <= DT_LOAD;
            r_gate_h <= 1'b0;
            r_gate_l <= 1'b0;
          end
        end
        default: begin
          r_state  <= StDead;
          r_tgt    <= w_req;
          r_cnt    <= DT_LOAD;
          r_gate_h <= 1'b0;
          r_gate_l <= 1'b0;
        end
      endcase
    end
  end

  assign gate_h = r_gate_h;
  assign gate_l = r_gate_l;

endmodule

// File: rtl/bldc_hall_commutator.sv
// Six-step hall commutator: sync, debounce, sector decode, PWM and dead-time gate drive.
// Define BLDC_HALL_PERIOD_EN to build the hall_period / period_valid measurement.
module bldc_hall_commutator
  import bldc_pkg::*;
#(
  parameter int unsigned PWM_WIDTH       = 8,
  parameter int unsigned DEADTIME_CYCLES = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           hall,
  input  logic                 enable,
  input  logic                 dir,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic                 fault_clr,
  output logic [2:0]           inh,
  output logic [2:0]           inl,
  output logic [2:0]           sector,
  output logic                 fault,
  output logic [23:0]          hall_period,
  output logic                 period_valid
);

  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES);

  logic [2:0]           r_sync [SYNC_STAGES];
  logic [2:0]           w_sync;
  logic [2:0]           r_cand;
  logic [15:0]          r_db_cnt;
  logic [15:0]          w_db_cnt_d;
  logic [2:0]           r_acc;
  logic                 r_acc_vld;
  logic [2:0]           w_dec;
  logic [2:0]           w_sector_d;
  logic                 w_inv;
  logic [2:0]           r_sector;
  logic                 r_fault;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic [PWM_WIDTH-1:0] r_duty;
  logic                 w_pwm_on;
  step_phases_t         w_ph;
  phase_req_e           w_req [3];
  logic [1:0]           r_req [3];

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_db_cnt_d = r_db_cnt;
    if (w_sync != r_cand)      w_db_cnt_d = 16'd1;
    else if (r_db_cnt != DB_MAX) w_db_cnt_d = r_db_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'd0;
      r_cand    <= 3'd0;
      r_db_cnt  <= 16'd0;
      r_acc     <= 3'd0;
      r_acc_vld <= 1'b0;
    end else begin
      r_sync[0] <= hall;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_cand   <= w_sync;
      r_db_cnt <= w_db_cnt_d;
      if (w_db_cnt_d == DB_MAX) begin
        r_acc     <= w_sync;
        r_acc_vld <= 1'b1;
      end
    end
  end

  // Nothing is decoded until a first code has been accepted, so reset never looks like a fault.
  assign w_dec      = hall_decode(r_acc);
  assign w_sector_d = r_acc_vld ? w_dec : r_sector;
  assign w_inv      = r_acc_vld && (w_dec == SECTOR_INVALID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sector <= SECTOR_INVALID;
      r_fault  <= 1'b0;
    end else begin
      r_sector <= w_sector_d;
      if (w_inv)                       r_fault <= 1'b1;
      else if (fault_clr && r_acc_vld) r_fault <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) r_duty <= duty;
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty);
  assign w_ph     = step_phases(step_of(r_sector, dir));

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_req[p] = ReqFloat;
      if (enable && !r_fault && (r_sector != SECTOR_INVALID)) begin
        if (w_ph.lo == 2'(p))                 w_req[p] = ReqLow;
        else if (w_ph.hi == 2'(p) && w_pwm_on) w_req[p] = ReqHigh;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 3; p++) r_req[p] <= ReqFloat;
    end else begin
      for (int p = 0; p < 3; p++) r_req[p] <= w_req[p];
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_phase
    bldc_phase_driver #(
      .DEADTIME_CYCLES(DEADTIME_CYCLES)
    ) u_drv (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (r_req[p]),
      .gate_h (inh[p]),
      .gate_l (inl[p])
    );
  end

  assign sector = r_sector;
  assign fault  = r_fault;

`ifdef BLDC_HALL_PERIOD_EN
  logic [23:0] r_per_cnt;
  logic [23:0] r_hall_period;
  logic        r_period_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_per_cnt      <= 24'd0;
      r_hall_period  <= 24'd0;
      r_period_valid <= 1'b0;
    end else if (w_sector_d != r_sector) begin
      r_per_cnt      <= 24'd1;
      r_period_valid <= (w_sector_d != SECTOR_INVALID) && (r_sector != SECTOR_INVALID);
      if ((w_sector_d != SECTOR_INVALID) && (r_sector != SECTOR_INVALID)) begin
        r_hall_period <= r_per_cnt;
      end
    end else begin
      r_period_valid <= 1'b0;
      if (r_per_cnt != 24'hFF_FFFF) r_per_cnt <= r_per_cnt + 24'd1;
    end
  end

  assign hall_period  = r_hall_period;
  assign period_valid = r_period_valid;
`else
  assign hall_period  = 24'd0;
  assign period_valid = 1'b0;
`endif

endmodule
